// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared simpleCNN constants and window sequencer state encoding
package cnn_pkg;

  localparam int MNIST_H      = 28;
  localparam int MNIST_W      = 28;
  localparam int MNIST_PIXELS = MNIST_H * MNIST_W;
  localparam int DEF_K        = 5;
  localparam int DEF_PIX_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HOLD,
    ST_FIN
  } cws_state_e;

endpackage

// File: rtl/conv_window_sequencer_if.sv
// rtl/conv_window_sequencer_if.sv - pixel memory read port and window stream bundle
interface conv_window_sequencer_if import cnn_pkg::*; #(
  parameter int K      = DEF_K,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = 17
);
  logic                   MEM_RD;
  logic [ADDR_W-1:0]      MEM_ADDR;
  logic [PIX_W-1:0]       MEM_DATA;
  logic [K*K*PIX_W-1:0]   WIN_DATA;
  logic [7:0]             WIN_X;
  logic [7:0]             WIN_Y;
  logic                   WIN_VALID;
  logic                   WIN_READY;

  modport master (
    output MEM_RD, MEM_ADDR, WIN_DATA, WIN_X, WIN_Y, WIN_VALID,
    input  MEM_DATA, WIN_READY
  );

  modport slave (
    input  MEM_RD, MEM_ADDR, WIN_DATA, WIN_X, WIN_Y, WIN_VALID,
    output MEM_DATA, WIN_READY
  );
endinterface

// File: rtl/conv_window_counter.sv
// rtl/conv_window_counter.sv - window origin and in-window tap counters
module conv_window_counter import cnn_pkg::*; #(
  parameter int K      = DEF_K,
  parameter int STRIDE = 1,
  parameter int LAST_X = 0,
  parameter int LAST_Y = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       tap_adv_i,
  input  logic       win_adv_i,
  output logic [7:0] x_o,
  output logic [7:0] y_o,
  output logic [7:0] x_nxt_o,
  output logic [7:0] y_nxt_o,
  output logic [7:0] i_nxt_o,
  output logic [7:0] j_nxt_o,
  output logic       tap_last_o,
  output logic       win_last_o
);

  logic [7:0] x_q, y_q, i_q, j_q;
  logic       y_last, j_last;

  // Next values are exported so the parent can address the upcoming tap in the same edge
  always_comb begin
    y_last     = (y_q == 8'(LAST_Y));
    j_last     = (j_q == 8'(K - 1));
    x_nxt_o    = y_last ? x_q + 8'(STRIDE) : x_q;
    y_nxt_o    = y_last ? 8'd0 : y_q + 8'(STRIDE);
    i_nxt_o    = j_last ? i_q + 8'd1 : i_q;
    j_nxt_o    = j_last ? 8'd0 : j_q + 8'd1;
    tap_last_o = j_last && (i_q == 8'(K - 1));
    win_last_o = y_last && (x_q == 8'(LAST_X));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      x_q <= '0;
      y_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else if (win_adv_i) begin
      x_q <= x_nxt_o;
      y_q <= y_nxt_o;
      i_q <= '0;
      j_q <= '0;
    end else if (tap_adv_i) begin
      i_q <= i_nxt_o;
      j_q <= j_nxt_o;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - fetches every KxK image window from pixel memory and streams it out
module conv_window_sequencer import cnn_pkg::*; #(
  parameter int IMG_W  = MNIST_W,
  parameter int IMG_H  = MNIST_H,
  parameter int K      = DEF_K,
  parameter int STRIDE = 1,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = 17
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  output logic              BUSY,
  output logic              DONE,
  conv_window_sequencer_if.master bus
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int NTAP  = K * K;
  localparam int IDX_W = $clog2(NTAP + 1);

  generate
    if (K > IMG_W || K > IMG_H || STRIDE < 1) begin : g_bad_cfg
      $error("conv_window_sequencer: K must fit the image and STRIDE must be >= 1");
    end
  endgenerate

  cws_state_e           state_q;
  logic [ADDR_W-1:0]    base_q, mem_addr_q, addr_d, base_sel;
  logic                 mem_rd_q, pend_q, win_valid_q, busy_q, done_q;
  logic [IDX_W-1:0]     rd_idx_q, pend_idx_q, idx_d;
  logic [NTAP*PIX_W-1:0] win_data_q;
  logic [7:0]           cx, cy, cx_n, cy_n, ci_n, cj_n, ox, oy, ti, tj;
  logic                 tap_last, win_last, xfer, clear, tap_adv, win_adv;

  conv_window_counter #(
    .K(K), .STRIDE(STRIDE), .LAST_X((OUT_H - 1) * STRIDE), .LAST_Y((OUT_W - 1) * STRIDE)
  ) u_cnt (
    .clk_i(CLK), .rst_i(RST), .clear_i(clear), .tap_adv_i(tap_adv), .win_adv_i(win_adv),
    .x_o(cx), .y_o(cy), .x_nxt_o(cx_n), .y_nxt_o(cy_n), .i_nxt_o(ci_n), .j_nxt_o(cj_n),
    .tap_last_o(tap_last), .win_last_o(win_last)
  );

  // The tap whose read is launched at this edge: first tap on START/transfer, else the next tap
  always_comb begin
    xfer     = (state_q == ST_HOLD) && bus.WIN_READY;
    clear    = ((state_q == ST_IDLE) && START) || (state_q == ST_FIN);
    tap_adv  = (state_q == ST_FETCH) && !tap_last;
    win_adv  = xfer && !win_last;
    ox       = cx;
    oy       = cy;
    ti       = ci_n;
    tj       = cj_n;
    base_sel = base_q;
    if (state_q == ST_IDLE) begin
      ox       = '0;
      oy       = '0;
      ti       = '0;
      tj       = '0;
      base_sel = BASE_ADDR;
    end else if (state_q == ST_HOLD) begin
      ox = cx_n;
      oy = cy_n;
      ti = '0;
      tj = '0;
    end
    addr_d = base_sel + (ADDR_W'(ox) + ADDR_W'(ti)) * ADDR_W'(IMG_W) + ADDR_W'(oy) + ADDR_W'(tj);
    idx_d  = IDX_W'(int'(ti) * K + int'(tj));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rd_idx_q    <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pend_q     <= mem_rd_q;
      pend_idx_q <= rd_idx_q;
      if (pend_q) win_data_q[int'(pend_idx_q) * PIX_W +: PIX_W] <= bus.MEM_DATA;
      case (state_q)
        ST_IDLE: if (START) begin
          base_q     <= BASE_ADDR;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= addr_d;
          rd_idx_q   <= idx_d;
          busy_q     <= 1'b1;
          state_q    <= ST_FETCH;
        end
        ST_FETCH: if (tap_last) begin
          mem_rd_q <= 1'b0;
          state_q  <= ST_DRAIN;
        end else begin
          mem_addr_q <= addr_d;
          rd_idx_q   <= idx_d;
        end
        ST_DRAIN: begin
          win_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: if (xfer) begin
          win_valid_q <= 1'b0;
          if (win_last) begin
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addr_d;
            rd_idx_q   <= idx_d;
            state_q    <= ST_FETCH;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.MEM_RD    = mem_rd_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.WIN_DATA  = win_data_q;
  assign bus.WIN_X     = cx;
  assign bus.WIN_Y     = cy;
  assign bus.WIN_VALID = win_valid_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - directed self-checking bench for conv_window_sequencer
module tb_conv_window_sequencer;
  import cnn_pkg::*;

  localparam int AW = 17;
  localparam int PW = 8;
  localparam int KK = 5;
  localparam int WW = KK * KK * PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, sel, ready;
  logic [AW-1:0] base;
  logic          busy_a, done_a, busy_b, done_b;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [7:0]    first_b24, last_b24;

  conv_window_sequencer_if #(.K(KK), .PIX_W(PW), .ADDR_W(AW)) ifa ();
  conv_window_sequencer_if #(.K(KK), .PIX_W(PW), .ADDR_W(AW)) ifb ();

  conv_window_sequencer #(.STRIDE(1)) dut_a (
    .CLK(clk), .RST(rst), .START(start && !sel), .BASE_ADDR(base),
    .BUSY(busy_a), .DONE(done_a), .bus(ifa)
  );
  conv_window_sequencer #(.STRIDE(2)) dut_b (
    .CLK(clk), .RST(rst), .START(start && sel), .BASE_ADDR(base),
    .BUSY(busy_b), .DONE(done_b), .bus(ifb)
  );

  assign ifa.WIN_READY = ready;
  assign ifb.WIN_READY = ready;

  // Pixel memory: each word holds the low byte of its own address
  always @(posedge clk) begin
    if (ifa.MEM_RD) ifa.MEM_DATA <= ifa.MEM_ADDR[7:0];
    if (ifb.MEM_RD) ifb.MEM_DATA <= ifb.MEM_ADDR[7:0];
  end

  logic          o_rd, o_valid, o_busy, o_done;
  logic [AW-1:0] o_addr;
  logic [WW-1:0] o_data;
  logic [7:0]    o_x, o_y;
  always_comb begin
    if (sel) begin
      o_rd = ifb.MEM_RD; o_addr = ifb.MEM_ADDR; o_data = ifb.WIN_DATA; o_x = ifb.WIN_X;
      o_y = ifb.WIN_Y; o_valid = ifb.WIN_VALID; o_busy = busy_b; o_done = done_b;
    end else begin
      o_rd = ifa.MEM_RD; o_addr = ifa.MEM_ADDR; o_data = ifa.WIN_DATA; o_x = ifa.WIN_X;
      o_y = ifa.WIN_Y; o_valid = ifa.WIN_VALID; o_busy = busy_a; o_done = done_a;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_win(input int b, input int x, input int y);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < KK; i++)
      for (int j = 0; j < KK; j++)
        w[(i * KK + j) * PW +: PW] = 8'(b + (x + i) * 28 + y + j);
    return w;
  endfunction

  task automatic scan(input bit s, input int b, input int pct, input bit poke);
    int stride, outd, nwin, nrd, cyc, ndone, ex, ey, first_addr, last_addr, bad_col, off;
    bit stall;
    logic [WW-1:0] pdata;
    logic [7:0] px, py;
    stride = s ? 2 : 1;
    outd = s ? 12 : 24;
    nwin = 0; nrd = 0; ndone = 0; ex = 0; ey = 0; first_addr = -1; last_addr = -1;
    bad_col = 0; stall = 1'b0; pdata = '0; px = '0; py = '0;
    sel = s; base = AW'(b); start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    base = AW'(b) ^ 17'h0ABCD;
    cyc = 1;
    while (ndone == 0 && cyc < 30000) begin
      ready = ($urandom_range(0, 99) < pct);
      if (poke) start = (cyc % 37 == 5);
      if (stall) chk("hold_stable", {o_valid, o_x, o_y, o_data}, {1'b1, px, py, pdata});
      if (o_rd) begin
        nrd++;
        if (first_addr < 0) first_addr = int'(o_addr);
        last_addr = int'(o_addr);
        off = int'(o_addr) - b;
        if (off % 28 == 27 || off / 28 == 27) bad_col++;
      end
      if (o_valid && ready) begin
        chk("win", {o_x, o_y, o_data}, {8'(ex), 8'(ey), exp_win(b, ex, ey)});
        if (nwin == 0) first_b24 = o_data[WW-1 -: 8];
        last_b24 = o_data[WW-1 -: 8];
        nwin++;
        ey += stride;
        if (ey > (outd - 1) * stride) begin
          ey = 0;
          ex += stride;
        end
      end
      stall = o_valid && !ready;
      px = o_x; py = o_y; pdata = o_data;
      if (o_done) ndone++;
      if (ndone == 0) begin
        tick;
        cyc++;
      end
    end
    start = 1'b0;
    chk("no_timeout", cyc < 30000, 1'b1);
    chk("busy_at_done", o_busy, 1'b1);
    chk("n_windows", nwin, outd * outd);
    chk("n_reads", nrd, outd * outd * KK * KK);
    chk("first_addr", first_addr, b);
    chk("last_addr", last_addr, b + ((outd - 1) * stride + 4) * 29);
    if (s) chk("edge_rows_cols_unread", bad_col, 0);
    if (pct == 100) chk("done_cycle", cyc, outd * outd * 27 + 1);
    tick;
    chk("done_pulse_busy_drop", {o_done, o_busy}, 2'b00);
    tick;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sel = 1'b0; ready = 1'b0; base = '0;
    repeat (3) tick;
    chk("reset_a", {o_rd, o_addr, o_data, o_x, o_y, o_valid, o_busy, o_done}, '0);
    sel = 1'b1;
    #1;
    chk("reset_b", {o_rd, o_addr, o_data, o_x, o_y, o_valid, o_busy, o_done}, '0);
    sel = 1'b0;
    rst = 1'b0;
    tick;

    scan(1'b0, 0, 100, 1'b0);
    chk("win00_byte24", first_b24, 8'h74);
    chk("win2323_byte24", last_b24, 8'h0F);

    scan(1'b0, 784, 100, 1'b1);
    scan(1'b0, 0, 30, 1'b0);
    scan(1'b1, 0, 100, 1'b0);

    // Reset mid-scan, then a fresh scan must start from origin with nominal latency
    sel = 1'b0; ready = 1'b1; base = '0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (39) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_scan", {o_rd, o_addr, o_data, o_x, o_y, o_valid, o_busy, o_done}, '0);
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    chk("rd_after_start", {o_rd, o_addr}, {1'b1, 17'd0});
    while (!o_valid && n < 100) begin
      tick;
      n++;
    end
    chk("rise_after_rst", n, 27);
    chk("win00_after_rst", {o_x, o_y, o_data}, {8'd0, 8'd0, exp_win(0, 0, 0)});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Parametrised window fetcher for the simpleCNN datapath. It reads an IMG_H×IMG_W pixel image from a synchronous single-port memory and emits every K×K convolution window, packed into one wide word, over a valid/ready handshake. It replaces bench-side window generation: raster order X outer, Y inner, with stride support, an image base address, and backpressure.

## Interface
- IMG_W, 28, image width (columns, Y axis)
- IMG_H, 28, image height (rows, X axis)
- K, 5, window edge; elaboration error if K > IMG_W or K > IMG_H
- STRIDE, 1, window step in both axes, ≥1
- PIX_W, 8, bits per pixel
- ADDR_W, 17, memory address width
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  begin a scan; sampled only in IDLE
- BASE_ADDR  in  ADDR_W  pixel address of image (0,0); latched on START
- MEM_RD  out  1  read strobe
- MEM_ADDR  out  ADDR_W  read address
- MEM_DATA  in  PIX_W  read data, valid the cycle after MEM_RD
- WIN_DATA  out  K*K*PIX_W  window; pixel (i,j) at [(i*K+j)*PIX_W +: PIX_W]
- WIN_X, WIN_Y  out  8 each  window origin (row, column)
- WIN_VALID  out  1  window available
- WIN_READY  in  1  consumer accepts
- BUSY  out  1  scan in progress
- DONE  out  1  one-cycle pulse after the last window transfers

## Operation
- OUT_W = (IMG_W−K)/STRIDE+1 and OUT_H = (IMG_H−K)/STRIDE+1, both floor. Columns and rows beyond the last full window are never read.
- States:
  - IDLE: wait for START.
  - FETCH: issue K*K reads, i outer, j inner, one per cycle. MEM_ADDR = BASE + (X+i)*IMG_W + (Y+j).
  - DRAIN: one cycle to capture the last datum.
  - HOLD: WIN_VALID=1 until WIN_READY.
  - FIN: DONE pulse.
- Transitions:
  - IDLE→FETCH on START.
  - FETCH→DRAIN after read K*K−1 issues.
  - DRAIN→HOLD.
  - In HOLD, on a transfer (VALID&READY) the window position advances: Y+=STRIDE. If Y was the last column, Y=0 and X+=STRIDE. From HOLD, go to FETCH if windows remain, else FIN.
  - FIN→IDLE.
- Each MEM_DATA is written into its WIN_DATA slot the cycle after its read. WIN_DATA, WIN_X and WIN_Y are stable throughout HOLD.
- BUSY=1 in every state except IDLE. START outside IDLE is ignored. BASE_ADDR changes after START have no effect.
- Address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W.
- RST in any state: next state IDLE. All outputs 0: MEM_RD, MEM_ADDR, WIN_DATA, WIN_X, WIN_Y, WIN_VALID, BUSY, DONE. Counters are cleared. In-flight read data is discarded.

## Timing
- START high on edge t:
  - MEM_RD is high in cycles t+1 … t+K*K.
  - WIN_VALID rises in cycle t+K*K+2 (t+27 at K=5).
- WIN_READY already high when VALID rises: the transfer happens that cycle, and the next FETCH starts the following cycle.
- Per-window period with no backpressure: K*K+2 cycles.
- DONE is high the cycle after the final transfer. BUSY drops in the same cycle as DONE falls; IDLE accepts START the next cycle.
- WIN_VALID never drops without a transfer, except on RST.

## Structure
- Shared package cnn_pkg holds:
  - MNIST constants: 28×28 image, 784 pixels per image.
  - Default K=5 and PIX_W=8.
  - The state enum for conv_window_sequencer.
- Sub-module conv_window_counter holds the nested counters: window origin X/Y with stride and last-window flags, and in-window i/j with a last-tap flag. It has an advance input and a clear input. The parent holds the FSM, the address adder and the WIN_DATA register.

## Test plan
- Default parameters, memory word = address[7:0], BASE=0:
  - 576 windows in X-outer order.
  - Window (0,0) byte 0 = 0x00, byte 24 = 0x74 (addr 116).
  - Last window (23,23) byte 24 = 0x0F (addr 783).
  - DONE pulses once.
- BASE_ADDR=784 (second image): first MEM_ADDR = 784, last MEM_ADDR = 1567. Data matches the reference model.
- STRIDE=2, K=5, 28×28: 12×12 = 144 windows; last origin is (22,22); row/column 27 is never addressed.
- Backpressure: WIN_READY random at 30%. WIN_DATA, WIN_X and WIN_Y stay stable while VALID && !READY. Window count and content are identical to the unthrottled run.
- START pulsed during FETCH and HOLD: ignored, no restart, BASE unchanged.
- RST at cycle 40 mid-scan:
  - Next cycle: all outputs 0 and BUSY=0.
  - A new START gives first window (0,0), rising 27 cycles after that START.
